// File: rtl/mul_dispatch.sv
// -----------------------------------------------------------------------------
// mul_dispatch
//
// Buffers operand pairs in a small FIFO and feeds them one at a time to an
// external shift-and-add multiplier, then holds each product until the
// consumer accepts it. After reset the block waits long enough for any
// multiplication still in progress to finish, because the multiplier has no
// reset of its own.
//
// Parameters
//   WIDTH  operand width (product is 2*WIDTH bits)
//   DEPTH  operand FIFO entries (power of two, >= 2)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_valid      operand pair offered
//   req_ready      FIFO can accept (low while draining or full)
//   req_a, req_b   multiplicand / multiplier
//   mul_in_valid   start pulse to the multiplier (ISSUE only)
//   mul_a, mul_b   operands to the multiplier (zero outside ISSUE)
//   mul_o          product from the multiplier
//   mul_out_valid  one-cycle done pulse from the multiplier
//   rsp_valid      product available
//   rsp_ready      consumer accepts
//   rsp_data       held product
//   err            sticky: done pulse seen when no multiply was outstanding
//
// Build option
//   MUL_DISPATCH_CONST_TIME_EN  when defined, every multiply takes exactly
//   WIDTH+3 cycles from ISSUE to response, independent of the operands.
// -----------------------------------------------------------------------------
`default_nettype none

module mul_dispatch #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               mul_in_valid,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_o,
    input  logic               mul_out_valid,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Timer must reach WIDTH+2, both for the drain period and the
    // constant-time wait.
    localparam int TMR_W = $clog2(WIDTH + 3);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIDTH + 2);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push, pop;
    logic [2*WIDTH-1:0] head;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               err_q, err_d;
`ifdef MUL_DISPATCH_CONST_TIME_EN
    logic               got_q, got_d;
`endif

    // Ready does not look at a same-cycle pop, so a full FIFO stalls for
    // one cycle even while ISSUE is freeing an entry.
    assign req_ready = (state_q != S_DRAIN) && (count_q < DEPTH_C);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_ISSUE);
    assign head      = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; count_q alone decides which entries are
    // live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_a, req_b};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_DRAIN;
            tmr_q      <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
`ifdef MUL_DISPATCH_CONST_TIME_EN
            got_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
`ifdef MUL_DISPATCH_CONST_TIME_EN
            got_q      <= got_d;
`endif
        end
    end

    // NOTE: every output of this block gets a default first, which is what
    // keeps synthesis from inferring latches on the unlisted paths.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        rsp_data_d   = rsp_data_q;
        err_d        = err_q;
`ifdef MUL_DISPATCH_CONST_TIME_EN
        got_d        = got_q;
`endif
        mul_in_valid = 1'b0;
        mul_a        = '0;
        mul_b        = '0;
        rsp_valid    = 1'b0;

        unique case (state_q)
            // Done pulses here belong to a multiply started before reset.
            S_DRAIN: begin
                if (tmr_q == TMR_LAST) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            S_IDLE: begin
                if (mul_out_valid) err_d = 1'b1;
                if (count_q != '0) state_d = S_ISSUE;
            end

            S_ISSUE: begin
                if (mul_out_valid) err_d = 1'b1;
                mul_in_valid   = 1'b1;
                {mul_a, mul_b} = head;
                state_d        = S_WAIT;
`ifdef MUL_DISPATCH_CONST_TIME_EN
                tmr_d = TMR_W'(1);
                got_d = 1'b0;
`endif
            end

            S_WAIT: begin
`ifdef MUL_DISPATCH_CONST_TIME_EN
                if (mul_out_valid && !got_q) begin
                    rsp_data_d = mul_o;
                    got_d      = 1'b1;
                end
                // Leave on the fixed boundary, not on the done pulse, so the
                // response time never reveals the operands.
                if (tmr_q == TMR_LAST) begin
                    state_d = S_RESP;
                    if (!got_q && !mul_out_valid) begin
                        err_d      = 1'b1;
                        rsp_data_d = '0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`else
                if (mul_out_valid) begin
                    rsp_data_d = mul_o;
                    state_d    = S_RESP;
                end
`endif
            end

            S_RESP: begin
                if (mul_out_valid) err_d = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end

            default: state_d = S_DRAIN;
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: doc/mul_dispatch.md
MUL_DISPATCH -- requirements
Module: mul_dispatch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; the product is 2*WIDTH bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the operand-FIFO entry count (power of two, at least 2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand pair offered
- req_ready  out  1  FIFO can accept
- req_a  in  WIDTH  multiplicand
- req_b  in  WIDTH  multiplier
- mul_in_valid  out  1  start pulse to the downstream shift-and-add multiplier
- mul_a  out  WIDTH  multiplicand to the multiplier
- mul_b  out  WIDTH  multiplier operand to the multiplier
- mul_o  in  2*WIDTH  product from the multiplier
- mul_out_valid  in  1  one-cycle done pulse from the multiplier
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts
- rsp_data  out  2*WIDTH  held product
- err  out  1  sticky: mul_out_valid seen outside WAIT

Function
REQ-005 Operand FIFO SHALL push {req_a, req_b} when req_valid && req_ready; req_ready = (count < DEPTH), independent of a same-cycle pop.
REQ-006 A push and a pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-007 FSM states SHALL be DRAIN, IDLE, ISSUE, WAIT, RESP.
REQ-008 DRAIN SHALL last exactly WIDTH+3 cycles, then move to IDLE; mul_out_valid SHALL be ignored in DRAIN, because the multiplier has no reset and may still be finishing.
REQ-009 IDLE SHALL move to ISSUE when count > 0; otherwise it SHALL stay in IDLE.
REQ-010 ISSUE SHALL last exactly one cycle, with mul_in_valid=1 and mul_a/mul_b = FIFO head; it SHALL pop the FIFO and move to WAIT.
REQ-011 mul_in_valid SHALL be 0 in every state except ISSUE; mul_a/mul_b SHALL be 0 outside ISSUE.
REQ-012 WAIT SHALL capture mul_o into rsp_data on the cycle mul_out_valid=1, then move to RESP.
REQ-013 RESP SHALL drive rsp_valid=1 and hold rsp_data stable until rsp_ready=1, then move to IDLE.
REQ-014 ISSUE SHALL therefore occur no earlier than 2 cycles after any mul_out_valid, which guarantees the multiplier is idle.
REQ-015 mul_out_valid in IDLE, ISSUE or RESP SHALL set err; in those states it SHALL NOT alter state or rsp_data; only reset SHALL clear err.
REQ-016 An accepted request with an empty FIFO in IDLE SHALL reach ISSUE 2 cycles after acceptance.

Reset
REQ-017 rst_n=0 SHALL immediately clear the FIFO (count 0), set state to DRAIN and err=0, and force req_ready=0, mul_in_valid=0, mul_a=0, mul_b=0, rsp_valid=0 and rsp_data=0.
REQ-018 req_ready SHALL be held at 0 during DRAIN.
REQ-019 Reset asserted mid-operation (WAIT or RESP) SHALL discard the in-flight product and any queued operands.

Configuration
REQ-020 With macro MUL_DISPATCH_CONST_TIME_EN defined, WAIT SHALL count cycles from ISSUE and move to RESP exactly WIDTH+3 cycles after ISSUE regardless of operands, capturing the product at its mul_out_valid pulse.
REQ-021 With MUL_DISPATCH_CONST_TIME_EN defined, if mul_out_valid has not occurred by the WIDTH+3 boundary, the block SHALL set err and return rsp_data=0.
REQ-022 Without MUL_DISPATCH_CONST_TIME_EN, the block SHALL leave WAIT on mul_out_valid, giving data-dependent latency.

Verification
REQ-023 Scenario: reset release -> req_ready=0 for WIDTH+3 cycles (35 at default), then 1.
REQ-024 Scenario: push a=3, b=5 with a model multiplier -> one mul_in_valid pulse carrying 3/5; rsp_data=15 held until rsp_ready; no second pulse.
REQ-025 Scenario: push 5 pairs back-to-back with DEPTH=4 -> 5th request stalls on req_ready=0; all 5 products return in order.
REQ-026 Scenario: b=0 vs b=0x80000000 with CONST_TIME_EN -> rsp_valid rises exactly ISSUE+35 for both; without the macro, the b=0 case returns earlier.
REQ-027 Scenario: stray mul_out_valid in IDLE -> err=1 and stays 1; state and rsp_data unchanged.
REQ-028 Scenario: rst_n pulsed low during WAIT -> outputs clear immediately; a late mul_out_valid arriving in DRAIN is ignored with err=0.
